// File: rtl/softmax_slot_scheduler.sv
// Dispatches tile row-streams onto a pool of softmax engines and retires finished
// rows in arrival order, pulsing a per-engine synchronous reset after each retirement.
module softmax_slot_scheduler #(
  parameter int NUM_SLOT      = 4,
  parameter int TILES_PER_ROW = 8,
  parameter int ROW_ID_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [NUM_SLOT-1:0]           slot_valid,
  input  logic [NUM_SLOT-1:0]           slot_done,
  output logic [NUM_SLOT-1:0]           slot_rst_n,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_SLOT)-1:0]   out_slot,
  output logic [ROW_ID_W-1:0]           out_row_id,
  output logic [$clog2(NUM_SLOT):0]     occupancy,
  output logic                          err_len,
  output logic [3*NUM_SLOT-1:0]         dbg_slot_state
);

  localparam int PW = $clog2(NUM_SLOT);
  localparam int CW = $clog2(TILES_PER_ROW + 1);

  // Handshakes: a tile moves when in_valid & in_ready; a row retires when
  // out_valid & out_ready. Neither valid depends on its own ready.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOADING   = 3'd1,
    S_COMPUTING = 3'd2,
    S_DONE      = 3'd3,
    S_CLEAR     = 3'd4
  } slot_state_e;

  slot_state_e         state_q  [NUM_SLOT];
  slot_state_e         state_d  [NUM_SLOT];
  logic [ROW_ID_W-1:0] row_id_q [NUM_SLOT];
  logic [ROW_ID_W-1:0] row_id_d [NUM_SLOT];
  logic [PW-1:0]       load_ptr_q, load_ptr_d;
  logic [PW-1:0]       ret_ptr_q, ret_ptr_d;
  logic [CW-1:0]       tile_cnt_q, tile_cnt_d;
  logic [ROW_ID_W-1:0] row_cnt_q, row_cnt_d;
  logic                err_len_q, err_len_d;
  logic [NUM_SLOT-1:0] slot_rst_n_q, slot_rst_n_d;

  logic          accept;
  logic          retire;
  logic          row_end;
  logic          load_idle;
  logic [CW-1:0] tile_num;
  logic [PW:0]   occ;

  always_comb begin
    in_ready   = rst_n & ((state_q[load_ptr_q] == S_IDLE) || (state_q[load_ptr_q] == S_LOADING));
    accept     = in_valid & in_ready;
    out_valid  = (state_q[ret_ptr_q] == S_DONE);
    retire     = out_valid & out_ready;
    load_idle  = (state_q[load_ptr_q] == S_IDLE);
    tile_num   = tile_cnt_q + CW'(1);
    row_end    = (tile_num == CW'(TILES_PER_ROW));

    load_ptr_d = load_ptr_q;
    ret_ptr_d  = ret_ptr_q;
    tile_cnt_d = tile_cnt_q;
    row_cnt_d  = row_cnt_q;
    err_len_d  = err_len_q;
    slot_valid = '0;
    occ        = '0;
    dbg_slot_state = '0;

    // Row end is decided by the tile count; in_last is only cross-checked.
    if (accept) begin
      tile_cnt_d = row_end ? '0 : tile_num;
      if (row_end) load_ptr_d = load_ptr_q + PW'(1);
      if (load_idle) row_cnt_d = row_cnt_q + ROW_ID_W'(1);
      if (in_last != row_end) err_len_d = 1'b1;
    end
    if (retire) ret_ptr_d = ret_ptr_q + PW'(1);

    for (int s = 0; s < NUM_SLOT; s++) begin
      state_d[s]  = state_q[s];
      row_id_d[s] = row_id_q[s];
      case (state_q[s])
        S_IDLE, S_LOADING: begin
          if (accept && (load_ptr_q == PW'(s))) begin
            slot_valid[s] = 1'b1;
            if (state_q[s] == S_IDLE) row_id_d[s] = row_cnt_q;
            state_d[s] = row_end ? S_COMPUTING : S_LOADING;
          end
        end
        S_COMPUTING: if (slot_done[s]) state_d[s] = S_DONE;
        S_DONE:      if (retire && (ret_ptr_q == PW'(s))) state_d[s] = S_CLEAR;
        S_CLEAR:     state_d[s] = S_IDLE;
        default:     state_d[s] = S_IDLE;
      endcase
      slot_rst_n_d[s] = (state_d[s] != S_CLEAR);
      if (state_q[s] != S_IDLE) occ = occ + (PW+1)'(1);
      dbg_slot_state[3*s +: 3] = state_q[s];
    end

    occupancy  = occ;
    out_slot   = ret_ptr_q;
    out_row_id = row_id_q[ret_ptr_q];
    err_len    = err_len_q;
    // The flop tracks CLEAR exactly; rst_n forces every engine into reset meanwhile.
    slot_rst_n = slot_rst_n_q & {NUM_SLOT{rst_n}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SLOT; s++) begin
        state_q[s]  <= S_IDLE;
        row_id_q[s] <= '0;
      end
      load_ptr_q   <= '0;
      ret_ptr_q    <= '0;
      tile_cnt_q   <= '0;
      row_cnt_q    <= '0;
      err_len_q    <= 1'b0;
      slot_rst_n_q <= '1;
    end else begin
      for (int s = 0; s < NUM_SLOT; s++) begin
        state_q[s]  <= state_d[s];
        row_id_q[s] <= row_id_d[s];
      end
      load_ptr_q   <= load_ptr_d;
      ret_ptr_q    <= ret_ptr_d;
      tile_cnt_q   <= tile_cnt_d;
      row_cnt_q    <= row_cnt_d;
      err_len_q    <= err_len_d;
      slot_rst_n_q <= slot_rst_n_d;
    end
  end

endmodule
